// File: rtl/alu_compare_sequencer_if.sv
// Operand/result handshake bundle for the nibble-serial magnitude comparator.
// The slave modport is the comparator; the master modport is its producer/consumer.
interface alu_compare_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_cmp;
  logic             res_valid;
  logic             res_ready;
  logic             eq;
  logic             greater;
  logic             less;

  modport slave (
    input  start_valid, a, b, signed_cmp, res_ready,
    output start_ready, res_valid, eq, greater, less
  );

  modport master (
    output start_valid, a, b, signed_cmp, res_ready,
    input  start_ready, res_valid, eq, greater, less
  );
endinterface

// File: rtl/alu_compare_sequencer.sv
// Nibble-serial magnitude comparator: walks two WIDTH-bit operands MSB nibble first,
// carrying eq/greater state between cycles, and exits early on the first mismatch.
module alu_compare_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  alu_compare_sequencer_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             signed_r;
  logic             eq_acc_r;
  logic             gt_acc_r;
  logic [IDX_W-1:0] idx_r;
  logic             idle_r;
  logic             res_valid_r;
  logic             eq_r;
  logic             greater_r;
  logic             less_r;

  logic [3:0]       na_s;
  logic [3:0]       nb_s;
  logic             flip_s;
  logic             gt_s;
  logic             lt_s;
  logic             eq_nxt_s;
  logic             gt_nxt_s;
  logic             finish_s;

  // Unsigned 4-bit slice compare, returned as {greater, less}.
  function automatic logic [1:0] nib_cmp(input logic [3:0] na, input logic [3:0] nb);
    return {(na > nb), (na < nb)};
  endfunction

  // Select the current nibble pair and fold it into the running eq/greater state.
  always_comb begin
    na_s = 4'd0;
    nb_s = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      na_s = (idx_r == IDX_W'(i)) ? a_r[i*4 +: 4] : na_s;
      nb_s = (idx_r == IDX_W'(i)) ? b_r[i*4 +: 4] : nb_s;
    end
    // Offset binary on the sign nibble turns a signed compare into an unsigned one.
    flip_s       = signed_r & (idx_r == TOP_IDX);
    na_s         = na_s ^ {flip_s, 3'b000};
    nb_s         = nb_s ^ {flip_s, 3'b000};
    {gt_s, lt_s} = nib_cmp(na_s, nb_s);
    eq_nxt_s     = eq_acc_r & ~gt_s & ~lt_s;
    gt_nxt_s     = gt_s | (gt_acc_r & ~lt_s);
    finish_s     = gt_s | lt_s | (idx_r == {IDX_W{1'b0}});
  end

  // Sequencer state, captured operands, accumulators and registered result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      signed_r    <= 1'b0;
      eq_acc_r    <= 1'b0;
      gt_acc_r    <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      idle_r      <= 1'b1;
      res_valid_r <= 1'b0;
      eq_r        <= 1'b0;
      greater_r   <= 1'b0;
      less_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_valid) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            signed_r <= bus.signed_cmp;
            eq_acc_r <= 1'b1;
            gt_acc_r <= 1'b0;
            idx_r    <= TOP_IDX;
            idle_r   <= 1'b0;
            state_r  <= RUN;
          end
        end
        RUN: begin
          eq_acc_r <= eq_nxt_s;
          gt_acc_r <= gt_nxt_s;
          if (finish_s) begin
            eq_r        <= eq_nxt_s;
            greater_r   <= gt_nxt_s;
            less_r      <= ~eq_nxt_s & ~gt_nxt_s;
            res_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            idle_r      <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          idle_r      <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Ready is forced low during reset even though the state already reads IDLE.
  assign bus.start_ready = idle_r & rst_n;
  assign bus.res_valid   = res_valid_r;
  assign bus.eq          = eq_r;
  assign bus.greater     = greater_r;
  assign bus.less        = less_r;
endmodule

// File: tb/tb_alu_compare_sequencer.sv
// Directed scoreboard bench for alu_compare_sequencer at WIDTH=8 and WIDTH=16.
module tb_alu_compare_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        sgn;
  logic        sv8;
  logic        sv16;
  logic        rr;
  logic        sel;
  int          tests = 0;
  int          fails = 0;

  typedef struct packed {
    logic       eq;
    logic       gt;
    logic       lt;
    logic [3:0] lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_compare_sequencer_if #(.WIDTH(8))  bus8 ();
  alu_compare_sequencer_if #(.WIDTH(16)) bus16 ();

  assign bus8.start_valid  = sv8;
  assign bus8.a            = a_in[7:0];
  assign bus8.b            = b_in[7:0];
  assign bus8.signed_cmp   = sgn;
  assign bus8.res_ready    = rr;
  assign bus16.start_valid = sv16;
  assign bus16.a           = a_in;
  assign bus16.b           = b_in;
  assign bus16.signed_cmp  = sgn;
  assign bus16.res_ready   = rr;

  alu_compare_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  alu_compare_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  logic o_valid, o_ready, o_eq, o_gt, o_lt;
  assign o_valid = sel ? bus16.res_valid   : bus8.res_valid;
  assign o_ready = sel ? bus16.start_ready : bus8.start_ready;
  assign o_eq    = sel ? bus16.eq          : bus8.eq;
  assign o_gt    = sel ? bus16.greater     : bus8.greater;
  assign o_lt    = sel ? bus16.less        : bus8.less;

  // Reference: native signed/unsigned compare; latency = nibbles up to first mismatch.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input int w);
    exp_t r;
    logic [15:0] xm, ym;
    logic signed [16:0] sx, sy;
    int nib;
    nib = w / 4;
    xm  = (w == 8) ? {8'h00, x[7:0]} : x;
    ym  = (w == 8) ? {8'h00, y[7:0]} : y;
    if (s) begin
      sx = (w == 8) ? 17'($signed(x[7:0])) : 17'($signed(x));
      sy = (w == 8) ? 17'($signed(y[7:0])) : 17'($signed(y));
    end else begin
      sx = {1'b0, xm};
      sy = {1'b0, ym};
    end
    r.eq  = (sx == sy);
    r.gt  = (sx > sy);
    r.lt  = (sx < sy);
    r.lat = 4'(nib);
    for (int i = nib - 1; i >= 0; i--) begin
      if (xm[i*4 +: 4] != ym[i*4 +: 4]) begin
        r.lat = 4'(nib - i);
        break;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic s, input int w);
    sel  = (w == 16);
    a_in = x;
    b_in = y;
    sgn  = s;
    if (sel) sv16 = 1'b1;
    else     sv8  = 1'b1;
    sb.push_back(model(x, y, s, w));
    tick();
    sv8  = 1'b0;
    sv16 = 1'b0;
    // Scramble inputs after acceptance; only the captured copies may matter.
    a_in = ~x;
    b_in = 16'h5A5A;
    sgn  = ~s;
  endtask

  task automatic wait_result(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (o_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " latency"}, 32'(n), 32'(e.lat));
      check({tag, " flags"}, {29'd0, o_eq, o_gt, o_lt}, {29'd0, e.eq, e.gt, e.lt});
    end
  endtask

  task automatic run(input logic [15:0] x, input logic [15:0] y, input logic s,
                     input int w, input string tag);
    sel = (w == 16);
    #0;
    check({tag, " ready_before"}, 32'(o_ready), 32'd1);
    start_op(x, y, s, w);
    wait_result(tag);
    tick();
    check({tag, " valid_after_hs"}, 32'(o_valid), 32'd0);
    check({tag, " ready_after_hs"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    a_in  = 16'h0000;
    b_in  = 16'h0000;
    sgn   = 1'b0;
    sv8   = 1'b0;
    sv16  = 1'b0;
    rr    = 1'b1;
    sel   = 1'b0;
    repeat (2) tick();
    check("rst valid", 32'(o_valid), 32'd0);
    check("rst flags", {29'd0, o_eq, o_gt, o_lt}, 32'd0);
    check("rst ready_low", 32'(o_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst ready_high", 32'(o_ready), 32'd1);

    run(16'h00A5, 16'h00A5, 1'b0, 8,  "u8_eq");
    run(16'h003F, 16'h0040, 1'b0, 8,  "u8_early_lt");
    run(16'h0080, 16'h0001, 1'b1, 8,  "s8_neg_lt");
    run(16'h0080, 16'h0001, 1'b0, 8,  "u8_gt");
    run(16'h007F, 16'h0080, 1'b1, 8,  "s8_pos_gt");
    run(16'h00FF, 16'h00FF, 1'b1, 8,  "s8_eq");
    run(16'h0037, 16'h0035, 1'b0, 8,  "u8_low_gt");
    run(16'h1234, 16'h1233, 1'b0, 16, "u16_gt");
    run(16'h1234, 16'h1234, 1'b1, 16, "s16_eq");
    run(16'h8000, 16'h7FFF, 1'b1, 16, "s16_lt");
    run(16'h8000, 16'h7FFF, 1'b0, 16, "u16_gt_top");

    // Backpressure: result held while start_valid is presented and must be ignored.
    rr = 1'b0;
    start_op(16'h0090, 16'h0010, 1'b0, 8);
    wait_result("bp");
    sv8  = 1'b1;
    a_in = 16'h0001;
    b_in = 16'h0002;
    sgn  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp hold_valid", 32'(o_valid), 32'd1);
      check("bp hold_flags", {29'd0, o_eq, o_gt, o_lt}, 32'b010);
      check("bp hold_ready", 32'(o_ready), 32'd0);
    end
    rr = 1'b1;
    tick();
    check("bp hs_valid", 32'(o_valid), 32'd0);
    check("bp hs_ready", 32'(o_ready), 32'd1);
    check("bp persist_idle", {29'd0, o_eq, o_gt, o_lt}, 32'b010);
    sb.push_back(model(16'h0001, 16'h0002, 1'b0, 8));
    tick();
    sv8 = 1'b0;
    check("bp accepted", 32'(o_ready), 32'd0);
    check("bp persist_run", {29'd0, o_eq, o_gt, o_lt}, 32'b010);
    wait_result("bp_next");
    tick();

    // Reset mid-RUN discards the operation.
    check("abort ready_before", 32'(o_ready), 32'd1);
    sv8  = 1'b1;
    a_in = 16'h0012;
    b_in = 16'h0013;
    tick();
    sv8   = 1'b0;
    rst_n = 1'b0;
    tick();
    check("abort valid", 32'(o_valid), 32'd0);
    check("abort flags", {29'd0, o_eq, o_gt, o_lt}, 32'd0);
    check("abort ready_low", 32'(o_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort ready_high", 32'(o_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort no_stale", 32'(o_valid), 32'd0);
    end
    run(16'h0012, 16'h0013, 1'b0, 8, "after_abort");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
